// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_seq_pkg: shared state, mode and direction encodings. Rev 1.0
// ----------------------------------------------------------------------------
package counter_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/counter_seq_ctrl_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_core: loadable up/down count register, load has priority over en. Rev 1.0
// ----------------------------------------------------------------------------
module counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= up ? (count_q + c_one) : (count_q - c_one);
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_seq_ctrl: start/stop sequencer with terminal-count flagging. Rev 1.0
// ----------------------------------------------------------------------------
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             mode_q, mode_d;
  logic             up_q, up_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic             w_load;
  logic             w_en;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_count_d;
  logic [WIDTH-1:0] w_term;
  logic             w_at_term;

  assign w_term    = (up_q == DIR_UP) ? lim_q : '0;
  assign w_at_term = (w_count == w_term);

  always_comb begin
    state_d    = state_q;
    lim_d      = lim_q;
    mode_d     = mode_q;
    up_d       = up_q;
    busy_d     = busy_q;
    done_d     = done_q;
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_load_val = (up_q == DIR_UP) ? '0 : lim_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (start) begin
          lim_d      = load_val;
          mode_d     = mode;
          up_d       = dir;
          w_load     = 1'b1;
          w_load_val = (dir == DIR_UP) ? '0 : load_val;
          state_d    = ST_RUN;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (w_at_term) begin
          if (mode_q == MODE_PERIODIC) begin
            w_load = 1'b1;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Look ahead at the post-edge count so tc_pulse lines up with count==T.
  always_comb begin
    if (w_load) begin
      w_count_d = w_load_val;
    end else if (w_en) begin
      w_count_d = (up_q == DIR_UP) ? (w_count + c_one) : (w_count - c_one);
    end else begin
      w_count_d = w_count;
    end
    tc_d = (state_d == ST_RUN) &&
           (w_count_d == ((up_d == DIR_UP) ? lim_d : '0));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lim_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      up_q    <= DIR_DOWN;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
      up_q    <= up_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .up       (up_q),
    .count    (w_count)
  );

  assign count    = w_count;
  assign busy     = busy_q;
  assign tc_pulse = tc_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_counter_seq_ctrl: scoreboard bench against a run-position reference model. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic       dir;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       busy;
  logic       tc_pulse;
  logic       done;

  counter_seq_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .dir      (dir),
    .load_val (load_val),
    .count    (count),
    .busy     (busy),
    .tc_pulse (tc_pulse),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] count;
    logic       busy;
    logic       tc;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // Model: a run is a walk of k = 0..lim steps; count is k (up) or lim-k (down).
  bit         m_run, m_fin, m_up, m_per;
  logic [7:0] m_lim, m_hold;
  int         m_k;

  function automatic logic [7:0] m_count();
    if (m_run || m_fin) return m_up ? 8'(m_k) : 8'(int'(m_lim) - m_k);
    return m_hold;
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    e.count = m_count();
    e.busy  = m_run;
    e.tc    = m_run && (m_k == int'(m_lim));
    e.done  = m_fin;
    return e;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit p, input bit md,
                     input bit d, input logic [7:0] lv);
    @(negedge clk);
    rst = r; start = s; stop = p; mode = md; dir = d; load_val = lv;
    if (!r) begin
      m_run = 0; m_fin = 0; m_up = 0; m_per = 0; m_lim = 0; m_hold = 0; m_k = 0;
    end else if (p && (m_run || m_fin)) begin
      m_hold = m_count();
      m_run  = 0;
      m_fin  = 0;
    end else if (s && !p && !m_run) begin
      m_lim = lv; m_up = d; m_per = md; m_k = 0; m_run = 1; m_fin = 0;
    end else if (m_run) begin
      if (m_k == int'(m_lim)) begin
        if (m_per) m_k = 0;
        else begin
          m_run = 0;
          m_fin = 1;
        end
      end else begin
        m_k++;
      end
    end
    q.push_back(m_out());
  endtask

  // Cycles with no command; config inputs wiggle to show they are ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1, 0, 0, 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    cyc_no++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{count: count, busy: busy, tc: tc_pulse, done: done};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got count=%0d busy=%b tc=%b done=%b, expected count=%0d busy=%b tc=%b done=%b",
                 cyc_no, a.count, a.busy, a.tc, a.done, e.count, e.busy, e.tc, e.done);
      end
    end
  end

  initial begin
    rst = 0; start = 0; stop = 0; mode = 0; dir = 0; load_val = 0;
    m_run = 0; m_fin = 0; m_up = 0; m_per = 0; m_lim = 0; m_hold = 0; m_k = 0;

    // Reset dominates a start request.
    cyc(0, 1, 0, 0, 0, 8'h05);
    cyc(0, 1, 0, 0, 0, 8'h05);

    // One-shot down from 3, then restart from DONE.
    cyc(1, 1, 0, 0, 0, 8'd3);
    idle(6);
    cyc(1, 1, 0, 0, 0, 8'd9);
    idle(12);

    // Periodic up to 2 with ignored starts, then stop mid-run.
    cyc(1, 1, 0, 1, 1, 8'd2);
    for (int i = 0; i < 8; i++) cyc(1, 1'($urandom), 0, 0, 0, 8'd7);
    cyc(1, 0, 1, 0, 0, 8'd0);
    idle(3);

    // lim = 0 periodic, then lim = 255 one-shot up.
    cyc(1, 1, 0, 1, 1, 8'd0);
    idle(4);
    cyc(1, 0, 1, 0, 0, 8'd0);
    cyc(1, 1, 0, 0, 1, 8'hFF);
    idle(260);

    // start+stop together in IDLE stays idle.
    cyc(1, 0, 1, 0, 0, 8'd0);
    cyc(1, 1, 1, 0, 1, 8'd4);
    cyc(1, 1, 1, 1, 0, 8'd4);
    idle(2);

    // stop on the terminal cycle of a one-shot.
    cyc(1, 1, 0, 0, 0, 8'd2);
    idle(2);
    cyc(1, 0, 1, 0, 0, 8'd0);
    idle(2);

    // Reset mid-run at count 2, then a fresh run.
    cyc(1, 1, 0, 0, 0, 8'd5);
    idle(3);
    cyc(0, 0, 0, 0, 0, 8'd0);
    cyc(1, 1, 0, 0, 1, 8'd3);
    idle(6);

    // Randomized traffic with mostly short limits.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] lv;
      lv = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom), lv);
    end
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencing controller for a loadable up/down counter register built from synchronous-reset flops.
- Accepts start/stop commands, latches a limit, direction and mode, and steps the count each clock.
- Flags terminal count and, in one-shot mode, halts at terminal count; in periodic mode, reloads.
- Sits between control logic (software-visible or FSM) and the counter datapath; downstream timing logic consumes its terminal-count pulse.

Parameters:
- WIDTH, 8, counter and limit width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low; sampled on posedge clk.
- start  input  1  begin a count run; latches load_val/dir/mode.
- stop  input  1  abort the run; return to IDLE.
- mode  input  1  0 = one-shot, 1 = periodic.
- dir  input  1  1 = up (0 to limit), 0 = down (limit to 0).
- load_val  input  WIDTH  run limit.
- count  output  WIDTH  current counter value.
- busy  output  1  high while in RUN.
- tc_pulse  output  1  one cycle per terminal-count hit.
- done  output  1  level; high in DONE (one-shot complete).

Behaviour:
- All outputs are registered; no combinational input-to-output paths.
- Reset: rst==0 at posedge forces state=IDLE, count=0, busy=0, tc_pulse=0, done=0, latched config=0. Reset has priority over all other inputs, including mid-run.
- States:
  - IDLE (2'b00): counter holds its value.
  - RUN (2'b01): counter steps.
  - DONE (2'b10): one-shot finished; count holds the terminal value.
- IDLE/DONE with start=1 and stop=0:
  - latch lim=load_val, m=mode, up=dir;
  - count <= up ? 0 : lim;
  - state <= RUN; busy <= 1; done <= 0.
- Terminal value T = up ? lim : 0. tc_pulse is high exactly during RUN cycles in which count==T.
- RUN, count!=T: count <= count+1 (up) or count-1 (down). Never wraps inside a run.
- RUN, count==T:
  - one-shot: state <= DONE, busy <= 0, done <= 1, count holds.
  - periodic: count <= start value (0 or lim), stay in RUN.
- Latency: start sampled at edge N gives busy=1 from edge N onward. The first tc_pulse occupies the cycle after edge N+lim. A one-shot run shows done=1 after edge N+lim+1.
- lim==0: count starts at T. tc_pulse is high in the first RUN cycle. Periodic mode gives tc_pulse every cycle.
- stop=1 in RUN or DONE: next state IDLE, busy=0, done=0, tc_pulse=0, count holds. stop beats the terminal transition and beats a simultaneous start.
- start in RUN is ignored (no restart). start in DONE restarts.
- load_val/dir/mode changes during RUN have no effect until the next start.
- Illegal state encoding (2'b11) recovers to IDLE on the next edge.

Decomposition:
- Package counter_seq_pkg holds:
  - state type/localparams ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10;
  - MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1;
  - DIR_DOWN=1'b0, DIR_UP=1'b1.
- One sub-module, counter_core. It is a WIDTH-bit register with synchronous active-low rst, load (priority), load value, en and up inputs, and a count output.
- counter_seq_ctrl holds the FSM, the config latch and tc/done generation, and drives counter_core.

Test Plan:
- Reset: hold rst=0 for 2 edges with start=1, load_val=8'h05 -> count=0, busy=0, tc_pulse=0, done=0 throughout.
- One-shot down: start pulse with load_val=3, dir=0, mode=0 -> count 3,2,1,0, tc_pulse high only on the 0 cycle, then done=1, busy=0, count holds 0; start=1 in DONE restarts at 3.
- Periodic up: load_val=2, dir=1, mode=1 -> count 0,1,2,0,1,2,…, tc_pulse every third cycle, done stays 0; stop=1 mid-run -> IDLE, count frozen at its current value.
- Boundary lim=0 and lim=8'hFF:
  - lim=0 periodic -> tc_pulse high every RUN cycle, count=0.
  - lim=255 one-shot up -> tc_pulse after 255 steps, no wrap to 0.
- Simultaneous events:
  - start+stop in IDLE -> stays IDLE.
  - stop on the terminal cycle of a one-shot -> IDLE, done=0.
  - start during RUN -> ignored.
  - load_val change during RUN -> no effect.
- Reset mid-operation: rst=0 on count=2 of a 5-count down run -> next edge count=0, busy=0, state IDLE; a new start after rst=1 runs normally.
